serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `diff = a - b` plus a final borrow, one bit per clock, LSB first. It is built around the team's half-subtractor cell: two half subtractors form a full-subtract cell, and a registered borrow feeds it. The block sits downstream of the combinational half subtractor and turns it into a multi-bit sequential datapath. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/serial_subtractor_full_subtractor.sv | 43 ++++
 rtl/serial_subtractor.sv | 85 ++++++++
 tb/tb_serial_subtractor.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type, default
// operand width and the bit-counter sizing helper.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Legacy state codes kept as named constants so existing probes still decode them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle of the serial subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational full-subtract cell built from two half-subtractor cells.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x    (x),
    .y    (y),
    .d    (d1),
    .bout (b1)
  );

  // Second stage subtracts the incoming borrow; it can only borrow when x == y.
  half_subtractor u_hs1 (
    .x    (d1),
    .y    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bw_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bw_q),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            res_q    <= '0;
            bw_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          // New bit enters at the MSB so bit i lands at position i after WIDTH shifts.
          res_q <= {d, res_q[WIDTH-1:1]};
          bw_q  <= bout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            borrow_q <= bout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.diff       = res_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed vectors,
// backpressure, mid-operation reset and a back-to-back random sweep.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: 9-bit unsigned subtraction; top bit is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output int lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      step();
      t++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    d  = bus.diff;
    bo = bus.borrow_out;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   bus.in_ready,   1);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_diff"},       bus.diff,       0);
    check({tag, "_borrow_out"}, bus.borrow_out, 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         bo;
    int           lat;
    logic [W:0]   e;
    logic [W:0]   expq[$];
    int           cyc, last, got, issued;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    tbl[6] = '{8'h01, 8'hFF, 8'h02, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, d, bo, lat);
      check($sformatf("tbl%0d_diff", i),    d,   tbl[i].d);
      check($sformatf("tbl%0d_borrow", i),  bo,  tbl[i].bo);
      check($sformatf("tbl%0d_latency", i), lat, W);
    end

    // Backpressure with ignored in_valid pulses while busy
    bus.a        = 8'h5A;
    bus.b        = 8'h33;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("bp_busy_shift", bus.busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("bp_out_valid", bus.out_valid, 1);
    e = ref_sub(8'h5A, 8'h33);
    for (int i = 0; i < 5; i++) begin
      check("bp_diff_hold",   bus.diff,       e[W-1:0]);
      check("bp_borrow_hold", bus.borrow_out, e[W]);
      check("bp_in_ready",    bus.in_ready,   0);
      check("bp_valid_hold",  bus.out_valid,  1);
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp_taken_valid", bus.out_valid, 0);
    check("bp_taken_ready", bus.in_ready,  1);
    run_op(8'h21, 8'h42, d, bo, lat);
    e = ref_sub(8'h21, 8'h42);
    check("bp_next_diff",   d,  e[W-1:0]);
    check("bp_next_borrow", bo, e[W]);

    // Reset in the middle of an operation
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    step();
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, d, bo, lat);
    check("post_reset_diff",    d,   8'h0F);
    check("post_reset_borrow",  bo,  0);
    check("post_reset_latency", lat, W);

    // Back-to-back random sweep with both handshakes tied high
    cyc    = 0;
    last   = -1;
    got    = 0;
    issued = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          check("sweep_unexpected_result", 1, 0);
        end else begin
          e = expq.pop_front();
          check("sweep_diff",   bus.diff,       e[W-1:0]);
          check("sweep_borrow", bus.borrow_out, e[W]);
        end
        if (last >= 0) check("sweep_interval", cyc - last, W + 2);
        last = cyc;
        got++;
      end
      if (bus.in_ready) begin
        if (issued < 1000) begin
          bus.a = W'($urandom);
          bus.b = ($urandom_range(0, 7) == 0) ? bus.a : W'($urandom);
          expq.push_back(ref_sub(bus.a, bus.b));
          issued++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    check("sweep_count", got, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
